pipe_reg_em: RTL and testbench

//   Parametrised execute->memory pipeline register with stall, flush, valid tracking and

---
 rtl/pipe_reg_em.sv | 122 ++++++++++++
 tb/tb_pipe_reg_em.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_em.sv
// Execute->memory pipeline register: DEPTH slots with stall, flush, valid tracking,
// output write-enable gating and a saturating bubble counter for hazard debug.
module pipe_reg_em #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RD_WIDTH      = 5,
  parameter int unsigned DEPTH         = 1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     validE_i,
  input  logic [DATA_WIDTH-1:0]    alu_resultE_i,
  input  logic [DATA_WIDTH-1:0]    write_dataE_i,
  input  logic [RD_WIDTH-1:0]      rdE_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4E_i,
  input  logic                     reg_writeE_i,
  input  logic [1:0]               result_srcE_i,
  input  logic                     mem_writeE_i,
  input  logic                     cache_weE_i,
  output logic                     validM_o,
  output logic [DATA_WIDTH-1:0]    alu_resultM_o,
  output logic [DATA_WIDTH-1:0]    write_dataM_o,
  output logic [RD_WIDTH-1:0]      rdM_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4M_o,
  output logic                     reg_writeM_o,
  output logic [1:0]               result_srcM_o,
  output logic                     mem_writeM_o,
  output logic                     cache_weM_o,
  output logic [CNT_WIDTH-1:0]     bubble_cnt_o
);

  localparam int unsigned LAST = DEPTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Contents of one pipeline slot
  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [RD_WIDTH-1:0]      rd;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     reg_write;
    logic [1:0]               result_src;
    logic                     mem_write;
    logic                     cache_we;
  } slot_t;

  slot_t                 slot_q [DEPTH];
  slot_t                 e_slot;
  slot_t                 out_slot;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q;

  // Reject unsupported depths at elaboration
  if ((DEPTH < 1) || (DEPTH > 4)) begin : g_bad_depth
    $error("pipe_reg_em: DEPTH must be in 1..4");
  end

  // Bundle execute-stage inputs into a slot record
  always_comb begin
    e_slot            = '0;
    e_slot.valid      = validE_i;
    e_slot.alu_result = alu_resultE_i;
    e_slot.write_data = write_dataE_i;
    e_slot.rd         = rdE_i;
    e_slot.pc_plus4   = pc_plus4E_i;
    e_slot.reg_write  = reg_writeE_i;
    e_slot.result_src = result_srcE_i;
    e_slot.mem_write  = mem_writeE_i;
    e_slot.cache_we   = cache_weE_i;
  end

  // First slot: capture E inputs; flush clears valid only, stall holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q[0] <= '0;
    end else if (flush_i) begin
      slot_q[0].valid <= 1'b0;
    end else if (!stall_i) begin
      slot_q[0] <= e_slot;
    end
  end

  // Remaining slots shift forward under the same reset/flush/stall priority
  for (genvar k = 1; k < DEPTH; k++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        slot_q[k] <= '0;
      end else if (flush_i) begin
        slot_q[k].valid <= 1'b0;
      end else if (!stall_i) begin
        slot_q[k] <= slot_q[k-1];
      end
    end
  end

  // Count cycles the output slot is a bubble, saturating instead of wrapping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else if (!out_slot.valid && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign out_slot = slot_q[LAST];

  // Payload passes straight through; write enables are qualified by valid
  assign validM_o      = out_slot.valid;
  assign alu_resultM_o = out_slot.alu_result;
  assign write_dataM_o = out_slot.write_data;
  assign rdM_o         = out_slot.rd;
  assign pc_plus4M_o   = out_slot.pc_plus4;
  assign result_srcM_o = out_slot.result_src;
  assign reg_writeM_o  = out_slot.valid & out_slot.reg_write & (out_slot.rd != '0);
  assign mem_writeM_o  = out_slot.valid & out_slot.mem_write;
  assign cache_weM_o   = out_slot.valid & out_slot.cache_we;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_reg_em.sv
// Bench for pipe_reg_em: table of single-cycle vectors on a DEPTH=1 instance,
// plus a hand sequence on a DEPTH=3 / CNT_WIDTH=2 instance.
module tb_pipe_reg_em;

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rw;
    logic [1:0]  rs;
    logic        mw, cw;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rw;
    logic [1:0]  rs;
    logic        mw, cw;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_e;
  logic [31:0] alu_e, wd_e, pc_e;
  logic [4:0]  rd_e;
  logic        rw_e, mw_e, cw_e;
  logic [1:0]  rs_e;

  logic        v1, rw1, mw1, cw1;
  logic [31:0] alu1, wd1, pc1;
  logic [4:0]  rd1;
  logic [1:0]  rs1;
  logic [15:0] cnt1;

  logic        v3, rw3, mw3, cw3;
  logic [31:0] alu3, wd3, pc3;
  logic [4:0]  rd3;
  logic [1:0]  rs3;
  logic [1:0]  cnt3;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_reg_em #(.DEPTH(1), .CNT_WIDTH(16)) u_d1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .validE_i(valid_e),
    .alu_resultE_i(alu_e), .write_dataE_i(wd_e), .rdE_i(rd_e), .pc_plus4E_i(pc_e),
    .reg_writeE_i(rw_e), .result_srcE_i(rs_e), .mem_writeE_i(mw_e), .cache_weE_i(cw_e),
    .validM_o(v1), .alu_resultM_o(alu1), .write_dataM_o(wd1), .rdM_o(rd1),
    .pc_plus4M_o(pc1), .reg_writeM_o(rw1), .result_srcM_o(rs1), .mem_writeM_o(mw1),
    .cache_weM_o(cw1), .bubble_cnt_o(cnt1)
  );

  pipe_reg_em #(.DEPTH(3), .CNT_WIDTH(2)) u_d3 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .validE_i(valid_e),
    .alu_resultE_i(alu_e), .write_dataE_i(wd_e), .rdE_i(rd_e), .pc_plus4E_i(pc_e),
    .reg_writeE_i(rw_e), .result_srcE_i(rs_e), .mem_writeE_i(mw_e), .cache_weE_i(cw_e),
    .validM_o(v3), .alu_resultM_o(alu3), .write_dataM_o(wd3), .rdM_o(rd3),
    .pc_plus4M_o(pc3), .reg_writeM_o(rw3), .result_srcM_o(rs3), .mem_writeM_o(mw3),
    .cache_weM_o(cw3), .bubble_cnt_o(cnt3)
  );

  function automatic in_t mk_in(logic r, logic s, logic f, logic v, logic [31:0] a,
                                logic [31:0] w, logic [4:0] d, logic [31:0] p,
                                logic rw, logic [1:0] rs, logic mw, logic cw);
    in_t x;
    x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.alu = a; x.wd = w;
    x.rd = d; x.pc = p; x.rw = rw; x.rs = rs; x.mw = mw; x.cw = cw;
    return x;
  endfunction

  function automatic out_t mk_out(logic v, logic [31:0] a, logic [31:0] w, logic [4:0] d,
                                  logic [31:0] p, logic rw, logic [1:0] rs, logic mw,
                                  logic cw, logic [15:0] c);
    out_t x;
    x.valid = v; x.alu = a; x.wd = w; x.rd = d; x.pc = p;
    x.rw = rw; x.rs = rs; x.mw = mw; x.cw = cw; x.cnt = c;
    return x;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t x);
    rst = x.rst; stall = x.stall; flush = x.flush; valid_e = x.valid;
    alu_e = x.alu; wd_e = x.wd; rd_e = x.rd; pc_e = x.pc;
    rw_e = x.rw; rs_e = x.rs; mw_e = x.mw; cw_e = x.cw;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t  idle;
    idle = mk_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 2'd0, 0, 0);
    drive(mk_in(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 2'd0, 0, 0));

    // reset with busy inputs
    add(mk_in(1,0,0,1,32'hDEAD,32'hBEEF,5'd7,32'h100,1,2'd2,1,1), mk_out(0,0,0,0,0,0,0,0,0,16'd0));
    add(mk_in(1,0,0,1,32'hDEAD,32'hBEEF,5'd7,32'h100,1,2'd2,1,1), mk_out(0,0,0,0,0,0,0,0,0,16'd0));
    // pass-through, then rd=0 gating
    add(mk_in(0,0,0,1,32'h1234,32'h55,5'd5,32'h44,1,2'd1,0,0), mk_out(1,32'h1234,32'h55,5'd5,32'h44,1,2'd1,0,0,16'd1));
    add(mk_in(0,0,0,1,32'h77,32'h99,5'd0,32'h48,1,2'd0,1,1),   mk_out(1,32'h77,32'h99,5'd0,32'h48,0,2'd0,1,1,16'd1));
    // load 0xA then stall three cycles while offering 0xB
    add(mk_in(0,0,0,1,32'hA,32'h10,5'd3,32'h4C,1,2'd2,0,1),    mk_out(1,32'hA,32'h10,5'd3,32'h4C,1,2'd2,0,1,16'd1));
    for (int k = 0; k < 3; k++)
      add(mk_in(0,1,0,1,32'hB,32'h20,5'd4,32'h50,0,2'd3,1,0),  mk_out(1,32'hA,32'h10,5'd3,32'h4C,1,2'd2,0,1,16'd1));
    add(mk_in(0,0,0,1,32'hC,32'h30,5'd6,32'h54,1,2'd1,1,0),    mk_out(1,32'hC,32'h30,5'd6,32'h54,1,2'd1,1,0,16'd1));
    // flush together with stall: valid drops, payload holds
    add(mk_in(0,1,1,1,32'hD,32'h40,5'd8,32'h58,1,2'd0,1,1),    mk_out(0,32'hC,32'h30,5'd6,32'h54,0,2'd1,0,0,16'd1));
    add(mk_in(0,0,0,0,32'hE,32'h50,5'd9,32'h5C,1,2'd2,1,1),    mk_out(0,32'hE,32'h50,5'd9,32'h5C,0,2'd2,0,0,16'd2));
    add(mk_in(0,1,0,1,32'hF,32'h60,5'd10,32'h60,1,2'd3,1,1),   mk_out(0,32'hE,32'h50,5'd9,32'h5C,0,2'd2,0,0,16'd3));
    add(mk_in(0,0,0,1,32'h1111,32'h2222,5'd31,32'h60,1,2'd3,0,0), mk_out(1,32'h1111,32'h2222,5'd31,32'h60,1,2'd3,0,0,16'd4));
    // reset mid-stream beats flush and stall
    add(mk_in(1,1,1,1,32'hFFFF,32'hEEEE,5'd12,32'h70,1,2'd1,1,1), mk_out(0,0,0,0,0,0,0,0,0,16'd0));
    add(idle,                                                   mk_out(0,0,0,0,0,0,0,0,0,16'd1));
    // flush alone
    add(mk_in(0,0,0,1,32'hABCD,32'h3,5'd2,32'h64,1,2'd1,1,1),  mk_out(1,32'hABCD,32'h3,5'd2,32'h64,1,2'd1,1,1,16'd2));
    add(mk_in(0,0,1,1,32'h9999,32'h8,5'd4,32'h68,1,2'd2,1,1),  mk_out(0,32'hABCD,32'h3,5'd2,32'h64,0,2'd1,0,0,16'd2));
    add(idle,                                                   mk_out(0,0,0,0,0,0,0,0,0,16'd3));

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].i);
      step();
      check($sformatf("v%0d.valid", n), 64'(v1),   64'(vecs[n].o.valid));
      check($sformatf("v%0d.alu", n),   64'(alu1), 64'(vecs[n].o.alu));
      check($sformatf("v%0d.wd", n),    64'(wd1),  64'(vecs[n].o.wd));
      check($sformatf("v%0d.rd", n),    64'(rd1),  64'(vecs[n].o.rd));
      check($sformatf("v%0d.pc", n),    64'(pc1),  64'(vecs[n].o.pc));
      check($sformatf("v%0d.rw", n),    64'(rw1),  64'(vecs[n].o.rw));
      check($sformatf("v%0d.rs", n),    64'(rs1),  64'(vecs[n].o.rs));
      check($sformatf("v%0d.mw", n),    64'(mw1),  64'(vecs[n].o.mw));
      check($sformatf("v%0d.cw", n),    64'(cw1),  64'(vecs[n].o.cw));
      check($sformatf("v%0d.cnt", n),   64'(cnt1), 64'(vecs[n].o.cnt));
    end

    // DEPTH=3: reset, then idle cycles saturate the 2-bit counter
    drive(mk_in(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 2'd0, 0, 0));
    step();
    check("d3.rst.valid", 64'(v3), 64'(0));
    check("d3.rst.alu",   64'(alu3), 64'(0));
    check("d3.rst.cnt",   64'(cnt3), 64'(0));
    drive(idle);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_c;
      exp_c = (k < 3) ? 2'(k + 1) : 2'd3;
      step();
      check($sformatf("d3.idle%0d.cnt", k), 64'(cnt3), 64'(exp_c));
    end

    // DEPTH=3 stream 1,2,(stall),3 then idle; output lags by three edges
    begin
      logic [31:0] s_alu  [7];
      logic        s_stl  [7];
      logic        s_val  [7];
      logic        x_val  [7];
      logic [31:0] x_alu  [7];
      s_alu = '{32'h1, 32'h2, 32'h77, 32'h3, 32'h0, 32'h0, 32'h0};
      s_stl = '{0, 0, 1, 0, 0, 0, 0};
      s_val = '{1, 1, 1, 1, 0, 0, 0};
      x_val = '{0, 0, 0, 1, 1, 1, 0};
      x_alu = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h0};
      for (int k = 0; k < 7; k++) begin
        drive(mk_in(0, s_stl[k], 0, s_val[k], s_alu[k], 32'h0, 5'd5, 32'h0, 1, 2'd0, 0, 0));
        step();
        check($sformatf("d3.s%0d.valid", k), 64'(v3),   64'(x_val[k]));
        check($sformatf("d3.s%0d.alu", k),   64'(alu3), 64'(x_alu[k]));
        check($sformatf("d3.s%0d.rw", k),    64'(rw3),  64'(x_val[k]));
        check($sformatf("d3.s%0d.cnt", k),   64'(cnt3), 64'(3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
